// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - request, response and data-memory signal bundle for mem_access_unit
//
// Purpose: groups the decoder-side request/response handshake and the data
// memory port of mem_access_unit into one parameterised bundle.
//
// Signals:
//   req_valid/req_ready       request handshake (decoder -> unit)
//   req_op, req_sel           decoded memory op (NOP/LOAD/STORE/illegal) and funct3 width code
//   req_addr, req_wdata       byte address and store data
//   req_rd                    destination register tag
//   resp_valid                one-cycle response strobe (unit -> writeback)
//   resp_rdata, resp_rd       extended load data and echoed tag
//   resp_err                  misaligned, illegal or timed-out request
//   dmem_en/we/be/addr/wdata  data memory request (unit -> memory)
//   dmem_rdata, dmem_ack      data memory completion (memory -> unit)
//
// Modports: slave is the access unit itself, master is its environment.

interface mem_access_unit_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [2:0]        req_sel;
  logic [ADDR_W-1:0] req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic [4:0]        req_rd;

  logic              resp_valid;
  logic [XLEN-1:0]   resp_rdata;
  logic [4:0]        resp_rd;
  logic              resp_err;

  logic              dmem_en;
  logic              dmem_we;
  logic [XLEN/8-1:0] dmem_be;
  logic [ADDR_W-1:0] dmem_addr;
  logic [XLEN-1:0]   dmem_wdata;
  logic [XLEN-1:0]   dmem_rdata;
  logic              dmem_ack;

  modport slave (
    input  req_valid, req_op, req_sel, req_addr, req_wdata, req_rd,
    input  dmem_rdata, dmem_ack,
    output req_ready,
    output resp_valid, resp_rdata, resp_rd, resp_err,
    output dmem_en, dmem_we, dmem_be, dmem_addr, dmem_wdata
  );

  modport master (
    output req_valid, req_op, req_sel, req_addr, req_wdata, req_rd,
    output dmem_rdata, dmem_ack,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_rd, resp_err,
    input  dmem_en, dmem_we, dmem_be, dmem_addr, dmem_wdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - sequential load/store unit between decoded memory ops and the data memory port
//
// Purpose: accepts one decoded load/store at a time, checks legality and
// alignment, performs a byte-enabled word-aligned memory access with a
// bounded wait for acknowledge, and returns extended load data or an error.
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  mem_access_unit_if.slave: request handshake, response strobe and
//        data memory port (see the interface file for the signal list)
//
// Parameters: XLEN (32 or 64), ADDR_W (byte address width), TIMEOUT (>= 1
// wait cycles before an unacknowledged access is abandoned).

module mem_access_unit #(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 15
) (
  input logic              clk,
  input logic              rst,
  mem_access_unit_if.slave bus
);

  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic [OFF_W-1:0] off_q;   // byte offset inside the bus word
  logic [1:0]       lsz_q;   // log2 of access size in bytes
  logic             sext_q;  // sign-extend the loaded value

  // ---------------------------------------------------------------------
  // Request decode (evaluated against the live request in IDLE)
  // ---------------------------------------------------------------------
  logic             is_nop;
  logic             op_ok;
  logic             sel_ok;
  logic             misaligned;
  logic [OFF_W-1:0] off_c;
  int               size_c;
  logic [NB-1:0]    be_ones;
  logic [NB-1:0]    be_c;
  logic [XLEN-1:0]  wdata_c;

  always_comb begin
    is_nop     = (bus.req_op == 2'b00);
    op_ok      = (bus.req_op == 2'b01) || (bus.req_op == 2'b10);
    off_c      = bus.req_addr[OFF_W-1:0];
    size_c     = 1 << int'(bus.req_sel[1:0]);
    sel_ok     = 1'b0;
    misaligned = 1'b0;
    wdata_c    = '0;

    case (bus.req_sel)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: sel_ok = 1'b1;
      3'b011, 3'b110:                         sel_ok = (XLEN == 64);
      default:                                sel_ok = 1'b0;
    endcase

    case (bus.req_sel[1:0])
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = bus.req_addr[0];
      2'b10:   misaligned = |bus.req_addr[1:0];
      default: misaligned = |bus.req_addr[2:0];
    endcase

    // (1<<size)-1 wraps to all ones for a full-width access, which is the
    // wanted mask.
    be_ones = NB'((1 << size_c) - 1);
    be_c    = be_ones << off_c;

    // Replicate the low size bytes of the store data across every lane so
    // the memory sees the right byte whatever lane be selects.
    for (int i = 0; i < NB; i++) begin
      wdata_c[8*i +: 8] = bus.req_wdata[8*(i % size_c) +: 8];
    end
  end

  // ---------------------------------------------------------------------
  // Load data alignment and extension (used in the ack cycle)
  // ---------------------------------------------------------------------
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] ext_mask;
  logic            sign_bit;
  logic [XLEN-1:0] load_ext;

  always_comb begin
    shifted = bus.dmem_rdata >> {off_q, 3'b000};
    case (lsz_q)
      2'd0: begin
        ext_mask = XLEN'(64'h0000_0000_0000_00FF);
        sign_bit = shifted[7];
      end
      2'd1: begin
        ext_mask = XLEN'(64'h0000_0000_0000_FFFF);
        sign_bit = shifted[15];
      end
      2'd2: begin
        ext_mask = XLEN'(64'h0000_0000_FFFF_FFFF);
        sign_bit = shifted[31];
      end
      default: begin
        ext_mask = '1;
        sign_bit = shifted[XLEN-1];
      end
    endcase
    load_ext = (shifted & ext_mask) | ((sext_q && sign_bit) ? ~ext_mask : '0);
  end

  // ---------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      wait_cnt       <= '0;
      off_q          <= '0;
      lsz_q          <= '0;
      sext_q         <= 1'b0;
      bus.req_ready  <= 1'b1;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= '0;
      bus.resp_rd    <= '0;
      bus.resp_err   <= 1'b0;
      bus.dmem_en    <= 1'b0;
      bus.dmem_we    <= 1'b0;
      bus.dmem_be    <= '0;
      bus.dmem_addr  <= '0;
      bus.dmem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          // req_ready is high throughout IDLE, so req_valid alone accepts.
          if (bus.req_valid) begin
            bus.req_ready <= 1'b0;
            bus.resp_rd   <= bus.req_rd;
            if (is_nop) begin
              state          <= RESP;
              bus.resp_valid <= 1'b1;
              bus.resp_err   <= 1'b0;
              bus.resp_rdata <= '0;
            end else if (!op_ok || !sel_ok || misaligned) begin
              state          <= RESP;
              bus.resp_valid <= 1'b1;
              bus.resp_err   <= 1'b1;
              bus.resp_rdata <= '0;
            end else begin
              state          <= ACCESS;
              wait_cnt       <= '0;
              off_q          <= off_c;
              lsz_q          <= bus.req_sel[1:0];
              sext_q         <= ~bus.req_sel[2];
              bus.dmem_en    <= 1'b1;
              bus.dmem_we    <= (bus.req_op == 2'b10);
              bus.dmem_be    <= be_c;
              bus.dmem_addr  <= {bus.req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
              bus.dmem_wdata <= wdata_c;
            end
          end
        end

        ACCESS: begin
          // Ack is checked first so an ack in the final wait cycle succeeds.
          if (bus.dmem_ack) begin
            state          <= RESP;
            bus.resp_valid <= 1'b1;
            bus.resp_err   <= 1'b0;
            bus.resp_rdata <= bus.dmem_we ? '0 : load_ext;
            bus.dmem_en    <= 1'b0;
            bus.dmem_we    <= 1'b0;
          end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
            state          <= RESP;
            wait_cnt       <= wait_cnt + 1'b1;
            bus.resp_valid <= 1'b1;
            bus.resp_err   <= 1'b1;
            bus.resp_rdata <= '0;
            bus.dmem_en    <= 1'b0;
            bus.dmem_we    <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        RESP: begin
          state          <= IDLE;
          bus.resp_valid <= 1'b0;
          bus.req_ready  <= 1'b1;
        end

        default: begin
          state          <= IDLE;
          bus.resp_valid <= 1'b0;
          bus.req_ready  <= 1'b1;
          bus.dmem_en    <= 1'b0;
          bus.dmem_we    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - self-checking bench for mem_access_unit (XLEN 32 and 64 instances)

module tb_mem_access_unit;

  localparam int TIMEOUT = 15;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  // Shared stimulus, fanned out to both instances
  logic        req_valid;
  logic [1:0]  req_op;
  logic [2:0]  req_sel;
  logic [31:0] req_addr;
  logic [63:0] req_wdata;
  logic [4:0]  req_rd;
  logic [63:0] dmem_rdata;
  logic        dmem_ack;
  logic        use64 = 1'b0;

  mem_access_unit_if #(.XLEN(32), .ADDR_W(32)) if32 ();
  mem_access_unit_if #(.XLEN(64), .ADDR_W(32)) if64 ();

  assign if32.req_valid  = req_valid;
  assign if32.req_op     = req_op;
  assign if32.req_sel    = req_sel;
  assign if32.req_addr   = req_addr;
  assign if32.req_wdata  = req_wdata[31:0];
  assign if32.req_rd     = req_rd;
  assign if32.dmem_rdata = dmem_rdata[31:0];
  assign if32.dmem_ack   = dmem_ack;
  assign if64.req_valid  = req_valid;
  assign if64.req_op     = req_op;
  assign if64.req_sel    = req_sel;
  assign if64.req_addr   = req_addr;
  assign if64.req_wdata  = req_wdata;
  assign if64.req_rd     = req_rd;
  assign if64.dmem_rdata = dmem_rdata;
  assign if64.dmem_ack   = dmem_ack;

  mem_access_unit #(.XLEN(32), .ADDR_W(32), .TIMEOUT(TIMEOUT)) dut32 (.clk(clk), .rst(rst), .bus(if32.slave));
  mem_access_unit #(.XLEN(64), .ADDR_W(32), .TIMEOUT(TIMEOUT)) dut64 (.clk(clk), .rst(rst), .bus(if64.slave));

  // Monitor view of whichever instance is under test
  wire        mon_ready = use64 ? if64.req_ready  : if32.req_ready;
  wire        mon_valid = use64 ? if64.resp_valid : if32.resp_valid;
  wire        mon_err   = use64 ? if64.resp_err   : if32.resp_err;
  wire [63:0] mon_rdata = use64 ? if64.resp_rdata : {32'd0, if32.resp_rdata};
  wire [4:0]  mon_rd    = use64 ? if64.resp_rd    : if32.resp_rd;
  wire        mon_en    = use64 ? if64.dmem_en    : if32.dmem_en;
  wire        mon_we    = use64 ? if64.dmem_we    : if32.dmem_we;
  wire [7:0]  mon_be    = use64 ? if64.dmem_be    : {4'd0, if32.dmem_be};
  wire [31:0] mon_addr  = use64 ? if64.dmem_addr  : if32.dmem_addr;
  wire [63:0] mon_wdata = use64 ? if64.dmem_wdata : {32'd0, if32.dmem_wdata};

  typedef struct packed {
    int          lat;
    int          nvalid;
    int          en_cycles;
    logic        err;
    logic [63:0] rdata;
    logic [4:0]  rd;
    logic [7:0]  be;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic        we;
    logic        ready_at_accept;
    logic        busy_ready;
    logic        ready_after;
    logic        valid_after;
    logic        unstable;
  } obs_t;

  typedef struct packed {
    logic        err;
    logic        mem;
    logic        we;
    logic [7:0]  be;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    int          lat;
    int          en_cycles;
  } exp_t;

  // Reference model: what the unit should do for one request, from the
  // encoding rules and plain arithmetic on byte counts.
  function automatic exp_t model(input int xlen, input logic [1:0] op, input logic [2:0] sel,
                                 input logic [31:0] addr, input logic [63:0] wd, input int ack_k,
                                 input logic [63:0] rd);
    exp_t         e;
    int           nb, size, off;
    logic         legal;
    logic [127:0] lim, piece, acc, v;
    logic [63:0]  xmask;
    e     = '0;
    nb    = xlen / 8;
    size  = 1 << int'(sel[1:0]);
    xmask = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    legal = (sel != 3'd7) && !((sel == 3'd3 || sel == 3'd6) && xlen == 32);
    e.lat = 1;
    if (op == 2'b00) return e;
    if (op == 2'b11 || !legal || (addr % size) != 0) begin
      e.err = 1'b1;
      return e;
    end
    e.mem  = 1'b1;
    e.we   = (op == 2'b10);
    off    = int'(addr % nb);
    e.addr = addr - off;
    e.be   = 8'(((1 << size) - 1) << off);
    lim    = 128'd1 << (8 * size);
    piece  = {64'd0, wd} % lim;
    acc    = '0;
    for (int j = 0; j < nb / size; j++) acc = acc | (piece << (8 * size * j));
    e.wdata = acc[63:0] & xmask;
    if (ack_k >= TIMEOUT) begin
      e.err       = 1'b1;
      e.lat       = TIMEOUT + 1;
      e.en_cycles = TIMEOUT;
      return e;
    end
    e.lat       = ack_k + 2;
    e.en_cycles = ack_k + 1;
    if (!e.we) begin
      v = ({64'd0, rd & xmask} >> (8 * off)) % lim;
      if (sel < 3'd4 && v >= (lim >> 1)) v = v + (128'd1 << xlen) - lim;
      e.rdata = v[63:0] & xmask;
    end
    return e;
  endfunction

  // Issue one request at a negedge and follow it to its response; the
  // memory acknowledges in the ack_k-th (0-based) cycle dmem_en is high.
  task automatic run_req(input logic [1:0] op, input logic [2:0] sel, input logic [31:0] addr,
                         input logic [63:0] wd, input logic [4:0] rd, input int ack_k,
                         input logic [63:0] rdat, input logic spur, output obs_t o);
    o = '0;
    o.ready_at_accept = mon_ready;
    req_valid = 1'b1; req_op = op; req_sel = sel; req_addr = addr; req_wdata = wd; req_rd = rd;
    dmem_ack = spur; dmem_rdata = {$urandom, $urandom};
    @(negedge clk);
    req_valid = 1'b0; req_op = 2'($urandom); req_sel = 3'($urandom); req_addr = $urandom;
    dmem_ack = 1'b0;
    for (int cyc = 1; cyc <= 40 && o.nvalid == 0; cyc++) begin
      if (mon_ready) o.busy_ready = 1'b1;
      dmem_ack = 1'b0;
      dmem_rdata = {$urandom, $urandom};
      if (mon_en) begin
        if (o.en_cycles == 0) begin
          o.be = mon_be; o.addr = mon_addr; o.wdata = mon_wdata; o.we = mon_we;
        end else if (o.be !== mon_be || o.addr !== mon_addr || o.wdata !== mon_wdata || o.we !== mon_we) begin
          o.unstable = 1'b1;
        end
        if (o.en_cycles == ack_k) begin
          dmem_ack = 1'b1;
          dmem_rdata = rdat;
        end
        o.en_cycles = o.en_cycles + 1;
      end
      if (mon_valid) begin
        o.nvalid = o.nvalid + 1;
        o.lat = cyc; o.err = mon_err; o.rdata = mon_rdata; o.rd = mon_rd;
      end
      @(negedge clk);
    end
    dmem_ack = 1'b0;
    o.ready_after = mon_ready;
    o.valid_after = mon_valid;
  endtask

  task automatic test_reset;
    rst = 1'b1; req_valid = 1'b0; req_op = '0; req_sel = '0; req_addr = '0; req_wdata = '0; req_rd = '0;
    dmem_rdata = '0; dmem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    vectors++; if (mon_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b want 1", mon_ready); end
    vectors++; if ({mon_valid, mon_err, mon_en, mon_we} !== 4'b0) begin miscompares++; $display("FAIL reset_flags: got %b want 0000", {mon_valid, mon_err, mon_en, mon_we}); end
    vectors++; if ({mon_rdata, mon_rd, mon_be, mon_addr, mon_wdata} !== '0) begin miscompares++; $display("FAIL reset_buses: rdata %h rd %h be %h addr %h wdata %h want all 0", mon_rdata, mon_rd, mon_be, mon_addr, mon_wdata); end
    rst = 1'b0;
    @(negedge clk);
    vectors++; if (mon_ready !== 1'b1 || mon_valid !== 1'b0 || mon_en !== 1'b0) begin miscompares++; $display("FAIL post_reset: ready %b valid %b en %b want 1 0 0", mon_ready, mon_valid, mon_en); end
  endtask

  task automatic test_loads;
    obs_t o;
    run_req(2'b01, 3'b000, 32'h1001, 64'h0, 5'd2, 0, 64'h0000_80FF, 1'b0, o);
    vectors++; if (o.lat !== 2) begin miscompares++; $display("FAIL lb_latency: got %0d want 2", o.lat); end
    vectors++; if (o.addr !== 32'h1000) begin miscompares++; $display("FAIL lb_addr: got %h want 00001000", o.addr); end
    vectors++; if (o.be !== 8'b0010) begin miscompares++; $display("FAIL lb_be: got %b want 00000010", o.be); end
    vectors++; if (o.rdata !== 64'hFFFF_FF80) begin miscompares++; $display("FAIL lb_rdata: got %h want ffffff80", o.rdata); end
    vectors++; if (o.rd !== 5'd2 || o.err !== 1'b0) begin miscompares++; $display("FAIL lb_rd_err: got rd %0d err %b want 2 0", o.rd, o.err); end
    run_req(2'b01, 3'b101, 32'h1002, 64'h0, 5'd7, 3, 64'hBEEF_1234, 1'b0, o);
    vectors++; if (o.lat !== 5) begin miscompares++; $display("FAIL lhu_latency: got %0d want 5", o.lat); end
    vectors++; if (o.rdata !== 64'h0000_BEEF) begin miscompares++; $display("FAIL lhu_rdata: got %h want 0000beef", o.rdata); end
    run_req(2'b01, 3'b001, 32'h1002, 64'h0, 5'd8, 3, 64'hBEEF_1234, 1'b0, o);
    vectors++; if (o.rdata !== 64'hFFFF_BEEF) begin miscompares++; $display("FAIL lh_rdata: got %h want ffffbeef", o.rdata); end
  endtask

  task automatic test_store;
    obs_t o;
    run_req(2'b10, 3'b000, 32'h2003, 64'h0000_00A5, 5'd3, 1, 64'hDEAD_BEEF, 1'b0, o);
    vectors++; if (o.we !== 1'b1 || o.be !== 8'b1000) begin miscompares++; $display("FAIL sb_we_be: got we %b be %b want 1 00001000", o.we, o.be); end
    vectors++; if (o.wdata !== 64'hA5A5_A5A5 || o.addr !== 32'h2000) begin miscompares++; $display("FAIL sb_wdata_addr: got %h %h want a5a5a5a5 00002000", o.wdata, o.addr); end
    vectors++; if (o.rdata !== 64'h0 || o.err !== 1'b0 || o.lat !== 3) begin miscompares++; $display("FAIL sb_resp: got rdata %h err %b lat %0d want 0 0 3", o.rdata, o.err, o.lat); end
  endtask

  task automatic test_errors;
    obs_t o;
    logic [1:0] ops [4]  = '{2'b01, 2'b01, 2'b11, 2'b00};
    logic [2:0] sels [4] = '{3'b010, 3'b111, 3'b000, 3'b000};
    logic [31:0] adrs [4] = '{32'h1002, 32'h1000, 32'h1000, 32'h1000};
    logic        errs [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      run_req(ops[i], sels[i], adrs[i], 64'h1234, 5'(i + 9), 0, 64'hFFFF_FFFF, 1'b0, o);
      vectors++; if (o.err !== errs[i] || o.lat !== 1) begin miscompares++; $display("FAIL err_case%0d: got err %b lat %0d want %b 1", i, o.err, o.lat, errs[i]); end
      vectors++; if (o.en_cycles !== 0 || o.rdata !== 64'h0 || o.rd !== 5'(i + 9)) begin miscompares++; $display("FAIL err_case%0d_side: en_cycles %0d rdata %h rd %0d want 0 0 %0d", i, o.en_cycles, o.rdata, o.rd, i + 9); end
    end
  endtask

  task automatic test_timeout;
    obs_t o;
    run_req(2'b01, 3'b010, 32'h1000, 64'h0, 5'd4, 1000, 64'h0, 1'b0, o);
    vectors++; if (o.en_cycles !== TIMEOUT || o.lat !== TIMEOUT + 1) begin miscompares++; $display("FAIL timeout_cycles: en %0d lat %0d want %0d %0d", o.en_cycles, o.lat, TIMEOUT, TIMEOUT + 1); end
    vectors++; if (o.err !== 1'b1 || o.rdata !== 64'h0) begin miscompares++; $display("FAIL timeout_err: got err %b rdata %h want 1 0", o.err, o.rdata); end
    run_req(2'b01, 3'b010, 32'h1000, 64'h0, 5'd5, TIMEOUT - 1, 64'h1357_9BDF, 1'b0, o);
    vectors++; if (o.err !== 1'b0 || o.rdata !== 64'h1357_9BDF || o.lat !== TIMEOUT + 1) begin miscompares++; $display("FAIL last_cycle_ack: got err %b rdata %h lat %0d want 0 13579bdf %0d", o.err, o.rdata, o.lat, TIMEOUT + 1); end
  endtask

  task automatic test_reset_mid_access;
    int seen;
    req_valid = 1'b1; req_op = 2'b01; req_sel = 3'b010; req_addr = 32'h1000; req_rd = 5'd6;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    vectors++; if (mon_en !== 1'b1) begin miscompares++; $display("FAIL midrst_en_before: got %b want 1", mon_en); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++; if (mon_en !== 1'b0 || mon_ready !== 1'b1 || mon_be !== 8'h0) begin miscompares++; $display("FAIL midrst_after: en %b ready %b be %h want 0 1 00", mon_en, mon_ready, mon_be); end
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (mon_valid || mon_en) seen++;
      @(negedge clk);
    end
    vectors++; if (seen !== 0) begin miscompares++; $display("FAIL midrst_quiet: got %0d active cycles want 0", seen); end
  endtask

  task automatic test_xlen64;
    obs_t o;
    use64 = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    run_req(2'b01, 3'b011, 32'h0000_0008, 64'h0, 5'd10, 0, 64'h8123_4567_89AB_CDEF, 1'b0, o);
    vectors++; if (o.be !== 8'hFF || o.addr !== 32'h8) begin miscompares++; $display("FAIL ld_be_addr: got be %h addr %h want ff 00000008", o.be, o.addr); end
    vectors++; if (o.rdata !== 64'h8123_4567_89AB_CDEF || o.err !== 1'b0) begin miscompares++; $display("FAIL ld_rdata: got %h err %b want 8123456789abcdef 0", o.rdata, o.err); end
    run_req(2'b01, 3'b010, 32'h0000_0014, 64'h0, 5'd11, 1, 64'h8000_0001_0000_0000, 1'b0, o);
    vectors++; if (o.rdata !== 64'hFFFF_FFFF_8000_0001 || o.be !== 8'hF0) begin miscompares++; $display("FAIL lw64_sext: got %h be %h want ffffffff80000001 f0", o.rdata, o.be); end
  endtask

  task automatic test_random(input int n, input int xlen);
    obs_t o;
    exp_t e;
    logic [1:0]  op;
    logic [2:0]  sel;
    logic [31:0] addr;
    logic [63:0] wd, rdat;
    logic [4:0]  rd;
    int          r, k;
    for (int i = 0; i < n; i++) begin
      r = $urandom_range(0, 9);
      op = (r == 0) ? 2'b00 : (r == 1) ? 2'b11 : (r < 6) ? 2'b01 : 2'b10;
      sel = (op == 2'b00) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) addr = addr & ~32'((1 << int'(sel[1:0])) - 1);
      wd = {$urandom, $urandom}; rdat = {$urandom, $urandom}; rd = 5'($urandom);
      r = $urandom_range(0, 9);
      k = (r == 0) ? TIMEOUT + $urandom_range(0, 5) : (r == 1) ? TIMEOUT - 1 : $urandom_range(0, 4);
      e = model(xlen, op, sel, addr, wd, k, rdat);
      run_req(op, sel, addr, wd, rd, k, rdat, 1'($urandom_range(0, 1)), o);
      vectors++; if (o.lat !== e.lat || o.nvalid !== 1) begin miscompares++; $display("FAIL rnd%0d_%0d latency: got %0d (%0d strobes) want %0d", xlen, i, o.lat, o.nvalid, e.lat); end
      vectors++; if (o.err !== e.err) begin miscompares++; $display("FAIL rnd%0d_%0d err: got %b want %b (op %b sel %b addr %h)", xlen, i, o.err, e.err, op, sel, addr); end
      vectors++; if (o.rdata !== e.rdata) begin miscompares++; $display("FAIL rnd%0d_%0d rdata: got %h want %h", xlen, i, o.rdata, e.rdata); end
      vectors++; if (o.rd !== rd) begin miscompares++; $display("FAIL rnd%0d_%0d rd: got %0d want %0d", xlen, i, o.rd, rd); end
      vectors++; if (o.en_cycles !== e.en_cycles) begin miscompares++; $display("FAIL rnd%0d_%0d en_cycles: got %0d want %0d", xlen, i, o.en_cycles, e.en_cycles); end
      if (e.mem) begin
        vectors++; if (o.be !== e.be || o.addr !== e.addr || o.we !== e.we) begin miscompares++; $display("FAIL rnd%0d_%0d bus: be %h addr %h we %b want %h %h %b", xlen, i, o.be, o.addr, o.we, e.be, e.addr, e.we); end
        vectors++; if (o.wdata !== e.wdata) begin miscompares++; $display("FAIL rnd%0d_%0d wdata: got %h want %h", xlen, i, o.wdata, e.wdata); end
        vectors++; if (o.unstable !== 1'b0) begin miscompares++; $display("FAIL rnd%0d_%0d bus_stable: got %b want 0", xlen, i, o.unstable); end
      end
      vectors++; if ({o.ready_at_accept, o.busy_ready, o.ready_after, o.valid_after} !== 4'b1010) begin miscompares++; $display("FAIL rnd%0d_%0d handshake: got %b want 1010", xlen, i, {o.ready_at_accept, o.busy_ready, o.ready_after, o.valid_after}); end
    end
  endtask

  initial begin
    test_reset;
    test_loads;
    test_store;
    test_errors;
    test_timeout;
    test_reset_mid_access;
    test_random(80, 32);
    test_xlen64;
    test_random(50, 64);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no completion want completion");
    $fatal(1, "watchdog");
  end

endmodule
